// File: rtl/ram_access_ctrl.sv
// CPU-to-RAM access sequencer: latches one request in IDLE, runs a single WRITE
// cycle or a READ_LAT-cycle READ, then pulses cpu_ack from DONE.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_out,
  output logic              ram_rw,
  input  logic [DATA_W-1:0] ram_data_in,
  output logic [DATA_W-1:0] data_debug,
  output logic [15:0]       debug_count
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(READ_LAT - 1);

  state_t              state_q, state_d;
  logic [1:0]          wait_q, wait_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [15:0]         debug_count_q, debug_count_d;

  // The direction is carried by the state itself, so cpu_we needs no flop.
  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    debug_count_d = debug_count_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wait_d  = '0;
          state_d = cpu_we ? WRITE : READ;
        end
      end
      WRITE: begin
        debug_count_d = debug_count_q + 16'd1;
        state_d       = DONE;
      end
      READ: begin
        if (wait_q == LAST_WAIT) begin
          rdata_d       = ram_data_in;
          debug_count_d = debug_count_q + 16'd1;
          state_d       = DONE;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      wait_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      debug_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      debug_count_q <= debug_count_d;
    end
  end

  // Strobes decode straight from the state flop so reset clears them at once.
  assign cpu_ack      = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign ram_rw       = (state_q == WRITE);
  assign ram_address  = addr_q;
  assign ram_data_out = wdata_q;
  assign cpu_rdata    = rdata_q;
  assign data_debug   = rdata_q;
  assign debug_count  = debug_count_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: transaction-timeline model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_ram_access_ctrl;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ack, busy, ram_rw;
  logic [15:0] cpu_rdata, ram_address, ram_data_out, ram_data_in, data_debug, debug_count;

  ram_access_ctrl #(.ADDR_W(16), .DATA_W(16), .READ_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .busy(busy),
    .ram_address(ram_address), .ram_data_out(ram_data_out), .ram_rw(ram_rw),
    .ram_data_in(ram_data_in), .data_debug(data_debug), .debug_count(debug_count)
  );

  always #10 clock = ~clock;

  // Bench-owned RAM: combinational read, write on ram_rw.
  logic [15:0] mem [256];
  assign ram_data_in = mem[ram_address[7:0]];
  always @(posedge clock) if (ram_rw) mem[ram_address[7:0]] <= ram_data_out;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request at edge s occupies edges s..ack_edge, where
  // ack_edge = s+1 (write) or s+LAT (read); the next sample is ack_edge+2 at earliest.
  int          e, s_edge, ack_edge;
  bit          active;
  logic        m_we;
  logic [15:0] m_addr, m_wdata, m_rdata, m_count;
  logic        exp_busy, exp_ack, exp_rw;
  logic [15:0] exp_addr, exp_dout, exp_rdata, exp_count;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      e = 0; s_edge = 0; ack_edge = 0; active = 0; m_we = 0;
      m_addr = 0; m_wdata = 0; m_rdata = 0; m_count = 0;
      exp_busy = 0; exp_ack = 0; exp_rw = 0;
      exp_addr = 0; exp_dout = 0; exp_rdata = 0; exp_count = 0;
    end else begin
      e++;
      if ((!active || e >= ack_edge + 2) && cpu_req) begin
        active   = 1;
        s_edge   = e;
        m_we     = cpu_we;
        m_addr   = cpu_addr;
        m_wdata  = cpu_wdata;
        ack_edge = e + (cpu_we ? 1 : LAT);
      end
      if (active && e == ack_edge) begin
        m_count = m_count + 16'd1;
        if (!m_we) m_rdata = mem[m_addr[7:0]];
      end
      exp_busy  = active && e >= s_edge && e <= ack_edge;
      exp_ack   = active && e == ack_edge;
      exp_rw    = active && m_we && e == s_edge;
      exp_addr  = m_addr;
      exp_dout  = m_wdata;
      exp_rdata = m_rdata;
      exp_count = m_count;
    end
  end

  always @(negedge clock) begin
    chk("m_busy",  busy,         exp_busy);
    chk("m_ack",   cpu_ack,      exp_ack);
    chk("m_rw",    ram_rw,       exp_rw);
    chk("m_addr",  ram_address,  exp_addr);
    chk("m_dout",  ram_data_out, exp_dout);
    chk("m_rdata", cpu_rdata,    exp_rdata);
    chk("m_dbg",   data_debug,   exp_rdata);
    chk("m_count", debug_count,  exp_count);
  end

  // Present a request at the current negedge; return at the negedge after the sampling edge.
  task automatic start(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clock);
    cpu_req = 0;
  endtask

  int acks, last_c;

  initial begin
    reset = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 257);
    mem[8'h20] = 16'hA5A5;
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_count", debug_count, 0);
    chk("rst_rw", ram_rw, 0);
    reset = 1;
    repeat (2) @(negedge clock);

    // Single write
    start(1, 16'h0010, 16'hBEEF);
    chk("wr_rw", ram_rw, 1);
    chk("wr_addr", ram_address, 16'h0010);
    chk("wr_dout", ram_data_out, 16'hBEEF);
    chk("wr_ack_early", cpu_ack, 0);
    @(negedge clock);
    chk("wr_ack", cpu_ack, 1);
    chk("wr_count", debug_count, 1);
    @(negedge clock);
    chk("wr_idle", busy, 0);

    // Single read, RAM returns 0x1234
    mem[8'h10] = 16'h1234;
    start(0, 16'h0010, 16'h0000);
    chk("rd_busy", busy, 1);
    chk("rd_rw", ram_rw, 0);
    chk("rd_ack0", cpu_ack, 0);
    @(negedge clock);
    chk("rd_ack1", cpu_ack, 0);
    @(negedge clock);
    chk("rd_ack2", cpu_ack, 1);
    chk("rd_rdata", cpu_rdata, 16'h1234);
    chk("rd_dbg", data_debug, 16'h1234);
    chk("rd_count", debug_count, 2);
    @(negedge clock);

    // Inputs ignored while busy
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0010; cpu_wdata = 16'h5555;
    @(negedge clock);
    cpu_addr = 16'h00FF;
    chk("ign_addr_w", ram_address, 16'h0010);
    @(negedge clock);
    chk("ign_addr_d", ram_address, 16'h0010);
    @(negedge clock);
    chk("ign_addr_i", ram_address, 16'h0010);
    chk("ign_idle", busy, 0);
    cpu_req = 0;
    @(negedge clock);
    chk("ign_count", debug_count, 3);

    // Held request: back-to-back writes every 3 cycles
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0030; cpu_wdata = 16'h7777;
    acks = 0; last_c = 0;
    for (int c = 0; c < 30 && acks < 3; c++) begin
      @(negedge clock);
      if (cpu_ack) begin
        acks++;
        chk("held_count", debug_count, 32'(3 + acks));
        if (acks > 1) chk("held_period", c - last_c, 3);
        last_c = c;
        if (acks == 3) cpu_req = 0;
      end
    end
    cpu_req = 0;
    chk("held_acks", acks, 3);
    chk("held_rdata", cpu_rdata, 16'h1234);
    repeat (2) @(negedge clock);

    // Reset in the middle of a read
    start(0, 16'h0020, 16'h0000);
    chk("mid_busy", busy, 1);
    #5 reset = 0;
    #1;
    chk("mid_busy0", busy, 0);
    chk("mid_ack0", cpu_ack, 0);
    chk("mid_rw0", ram_rw, 0);
    chk("mid_addr0", ram_address, 0);
    chk("mid_dout0", ram_data_out, 0);
    chk("mid_rdata0", cpu_rdata, 0);
    chk("mid_dbg0", data_debug, 0);
    chk("mid_count0", debug_count, 0);
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    start(0, 16'h0020, 16'h0000);
    @(negedge clock);
    @(negedge clock);
    chk("post_ack", cpu_ack, 1);
    chk("post_rdata", cpu_rdata, 16'hA5A5);
    chk("post_count", debug_count, 1);
    @(negedge clock);

    // Counter wrap from 0xFFFF
    #2;
    force dut.debug_count_q = 16'hFFFF;
    m_count = 16'hFFFF;
    @(negedge clock);
    #2;
    release dut.debug_count_q;
    chk("wrap_pre", debug_count, 16'hFFFF);
    start(1, 16'h0040, 16'h0001);
    @(negedge clock);
    chk("wrap_ack", cpu_ack, 1);
    chk("wrap_count", debug_count, 16'h0000);
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
